// File: rtl/rv32i_types.sv
// Shared types for the RV32I pipeline control slice.
// Contents:
//   hazard_state_t : sequencer state (RUN, REDIR_PEND)
package rv32i_types;

  typedef enum logic {
    RUN        = 1'b0,
    REDIR_PEND = 1'b1
  } hazard_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the ID instruction sources and the EX load.
// Ports:
//   ex_mem_read            : EX instruction is a load
//   ex_rd                  : EX destination register
//   id_rs1, id_rs2         : ID source registers
//   id_use_rs1, id_use_rs2 : ID instruction reads rs1 / rs2
//   hz                     : ID must wait one cycle for the load result
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic             hz
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hz = ex_mem_read && (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central load/flush sequencer for the five-stage RV32I pipeline.
// Arbitrates data-memory stalls, load-use hazards, fetch misses and EX
// redirects, and keeps performance counters.
//
// state      | meaning
// -----------+----------------------------------------------------------
// RUN        | normal issue; redirects applied at once when fetch is ready
// REDIR_PEND | redirect target latched, waiting for the wrong-path fetch
//            | to return so the PC can take the target
//
// Ports:
//   clk, rst                     : clock, async active-high reset
//   imem_resp                    : fetch data valid
//   dmem_req, dmem_resp          : MEM stage access pending / complete
//   id_rs1/2, id_use_rs1/2       : ID sources and their use flags
//   ex_rd, ex_mem_read           : EX destination and load flag
//   ex_br_taken                  : EX redirect request
//   load_pc, pc_sel_redirect     : PC enable and redirect mux select
//   redir_capture                : latch EX target into the redirect register
//   load_*, flush_*              : stage register enables / bubble inserts
//   stall_cycles, bubble_count,
//   redirect_count               : wrapping performance counters
module pipeline_hazard_ctrl
  import rv32i_types::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  output logic             load_pc,
  output logic             pc_sel_redirect,
  output logic             redir_capture,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] redirect_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hazard_state_t state, state_nxt;
  logic          hz;
  logic          mem_ok;
  logic          if_ok;
  logic          inc_stall, inc_bubble, inc_redir;

  assign mem_ok = ~dmem_req | dmem_resp;
  assign if_ok  = imem_resp;

  load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .hz          (hz)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (mem_ok) begin
      case (state)
        RUN:        if (ex_br_taken && !if_ok) state_nxt = REDIR_PEND;
        REDIR_PEND: if (if_ok)                 state_nxt = RUN;
        default:    state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    load_pc         = 1'b0;
    pc_sel_redirect = 1'b0;
    redir_capture   = 1'b0;
    load_if_id      = 1'b0;
    load_id_ex      = 1'b0;
    load_ex_mem     = 1'b0;
    load_mem_wb     = 1'b0;
    flush_if_id     = 1'b0;
    flush_id_ex     = 1'b0;
    inc_stall       = 1'b0;
    inc_bubble      = 1'b0;
    inc_redir       = 1'b0;
    if (rst) begin
      // everything held at zero
    end else if (!mem_ok) begin
      inc_stall = 1'b1;
    end else begin
      // Every path below advances the back end.
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      case (state)
        RUN: begin
          if (ex_br_taken) begin
            // Redirect beats hz: the ID instruction is wrong-path anyway.
            redir_capture   = 1'b1;
            load_if_id      = 1'b1;
            flush_if_id     = 1'b1;
            flush_id_ex     = 1'b1;
            load_pc         = if_ok;
            pc_sel_redirect = if_ok;
            inc_redir       = if_ok;
          end else if (hz) begin
            flush_id_ex = 1'b1;
            inc_bubble  = 1'b1;
          end else if (!if_ok) begin
            load_if_id  = 1'b1;
            flush_if_id = 1'b1;
          end else begin
            load_pc    = 1'b1;
            load_if_id = 1'b1;
          end
        end
        default: begin
          // Returned wrong-path word is dropped; the PC takes the latched target.
          load_if_id      = 1'b1;
          flush_if_id     = 1'b1;
          flush_id_ex     = 1'b1;
          load_pc         = if_ok;
          pc_sel_redirect = if_ok;
          inc_redir       = if_ok;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles   <= '0;
      bubble_count   <= '0;
      redirect_count <= '0;
    end else begin
      if (inc_stall)  stall_cycles   <= stall_cycles + CNT_ONE;
      if (inc_bubble) bubble_count   <= bubble_count + CNT_ONE;
      if (inc_redir)  redirect_count <= redirect_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// Output strobes are packed as
//   {load_pc, pc_sel_redirect, redir_capture,
//    load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
//    flush_if_id, flush_id_ex}
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  localparam logic [8:0] V_NONE      = 9'b000_0000_00;
  localparam logic [8:0] V_RUN       = 9'b100_1111_00;
  localparam logic [8:0] V_REDIR_NOW = 9'b111_1111_11;
  localparam logic [8:0] V_PEND_IN   = 9'b001_1111_11;
  localparam logic [8:0] V_PEND_BUB  = 9'b000_1111_11;
  localparam logic [8:0] V_PEND_OUT  = 9'b110_1111_11;
  localparam logic [8:0] V_HZ        = 9'b000_0111_01;
  localparam logic [8:0] V_IMISS     = 9'b000_1111_10;

  logic             clk = 1'b0;
  logic             rst;
  logic             imem_resp, dmem_req, dmem_resp;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken;
  logic             load_pc, pc_sel_redirect, redir_capture;
  logic             load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic             flush_if_id, flush_id_ex;
  logic [CNT_W-1:0] stall_cycles, bubble_count, redirect_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_resp       (imem_resp),
    .dmem_req        (dmem_req),
    .dmem_resp       (dmem_resp),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_br_taken     (ex_br_taken),
    .load_pc         (load_pc),
    .pc_sel_redirect (pc_sel_redirect),
    .redir_capture   (redir_capture),
    .load_if_id      (load_if_id),
    .load_id_ex      (load_id_ex),
    .load_ex_mem     (load_ex_mem),
    .load_mem_wb     (load_mem_wb),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .stall_cycles    (stall_cycles),
    .bubble_count    (bubble_count),
    .redirect_count  (redirect_count)
  );

  wire [8:0] strobes = {load_pc, pc_sel_redirect, redir_capture,
                        load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                        flush_if_id, flush_id_ex};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    imem_resp   = 1'b1;
    dmem_req    = 1'b0;
    dmem_resp   = 1'b0;
    id_rs1      = '0;
    id_rs2      = '0;
    id_use_rs1  = 1'b0;
    id_use_rs2  = 1'b0;
    ex_rd       = '0;
    ex_mem_read = 1'b0;
    ex_br_taken = 1'b0;
  endtask

  task automatic settle_check(input string tag, input logic [8:0] exp);
    #1;
    check(tag, 32'(strobes), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    check("rst_strobes", 32'(strobes), 32'(V_NONE));
    check("rst_stall", stall_cycles, 0);
    check("rst_bubble", bubble_count, 0);
    check("rst_redir", redirect_count, 0);
    step();
    rst = 1'b0;
    settle_check("run_idle", V_RUN);
    step();

    // load-use on rs2
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    settle_check("hz_rs2", V_HZ);
    step();
    check("hz_bubble_1", bubble_count, 1);
    // rs1 match but rs1 not used
    id_rs2 = 5'd6; id_rs1 = 5'd5; id_use_rs1 = 1'b0;
    settle_check("hz_rs1_unused", V_RUN);
    id_use_rs1 = 1'b1;
    settle_check("hz_rs1", V_HZ);
    step();
    check("hz_bubble_2", bubble_count, 2);
    // x0 destination never hazards
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    settle_check("hz_x0", V_RUN);
    step();
    check("hz_x0_bubble", bubble_count, 2);
    idle();

    // fetch miss only
    imem_resp = 1'b0;
    settle_check("imiss", V_IMISS);
    step();
    imem_resp = 1'b1;

    // data stall for 4 cycles
    dmem_req = 1'b1; dmem_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle_check($sformatf("dstall_%0d", i), V_NONE);
      step();
    end
    check("dstall_count", stall_cycles, 4);
    dmem_resp = 1'b1;
    settle_check("dstall_release", V_RUN);
    step();
    check("dstall_count_hold", stall_cycles, 4);
    idle();

    // redirect with fetch ready
    ex_br_taken = 1'b1;
    settle_check("redir_now", V_REDIR_NOW);
    step();
    check("redir_now_cnt", redirect_count, 1);
    ex_br_taken = 1'b0;
    settle_check("redir_now_stay_run", V_RUN);

    // redirect during fetch miss
    ex_br_taken = 1'b1; imem_resp = 1'b0;
    settle_check("redir_pend_in", V_PEND_IN);
    step();
    check("redir_pend_in_cnt", redirect_count, 1);
    for (int i = 0; i < 3; i++) begin
      ex_br_taken = (i == 1);
      settle_check($sformatf("redir_pend_bub_%0d", i), V_PEND_BUB);
      step();
    end
    ex_br_taken = 1'b0; imem_resp = 1'b1;
    settle_check("redir_pend_out", V_PEND_OUT);
    step();
    check("redir_pend_cnt", redirect_count, 2);
    settle_check("redir_back_run", V_RUN);
    step();

    // redirect + hz under data stall
    ex_br_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7;
    id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    dmem_req = 1'b1; dmem_resp = 1'b0;
    settle_check("prio_stall", V_NONE);
    step();
    check("prio_stall_cnt", stall_cycles, 5);
    check("prio_stall_redir", redirect_count, 2);
    dmem_resp = 1'b1;
    settle_check("prio_redir", V_REDIR_NOW);
    step();
    check("prio_redir_cnt", redirect_count, 3);
    check("prio_bubble_cnt", bubble_count, 2);
    idle();

    // reset while in REDIR_PEND
    ex_br_taken = 1'b1; imem_resp = 1'b0;
    step();
    ex_br_taken = 1'b0;
    settle_check("rst_pend_pre", V_PEND_BUB);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_strobes", 32'(strobes), 32'(V_NONE));
    check("rst_async_stall", stall_cycles, 0);
    check("rst_async_bubble", bubble_count, 0);
    check("rst_async_redir", redirect_count, 0);
    step();
    rst = 1'b0;
    imem_resp = 1'b1;
    settle_check("rst_release_run", V_RUN);
    step();
    check("rst_release_redir", redirect_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
